// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/arith ops plus iterative unsigned MUL/DIV with busy/done handshake.
// Optional ALU_HILO_EN builds a hi register holding the product high word or the division remainder.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi
);

`ifdef ALU_HILO_EN
    localparam int unsigned AccW = 2 * WIDTH;
`else
    localparam int unsigned AccW = WIDTH;
`endif
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpMul = 4'b0011;
    localparam logic [3:0] OpDiv = 4'b0100;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpNop = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } state_e;

    state_e            r_state, w_state_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_done;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_illegal;
    logic              r_div_zero;

    // Multiplier: shift-add, multiplicand moves left while multiplier moves right.
    logic [AccW-1:0]   r_mcand, w_mcand_nxt;
    logic [AccW-1:0]   r_acc, w_acc_nxt;
    logic [WIDTH-1:0]  r_mplier, w_mplier_nxt;

    // Divider: restoring, dividend bits shift out of r_quo as quotient bits shift in.
    logic [WIDTH-1:0]  r_dvsr, w_dvsr_nxt;
    logic [WIDTH-1:0]  r_quo, w_quo_nxt;
    logic [WIDTH-1:0]  r_rem, w_rem_nxt;

    logic              w_fin;
    logic [WIDTH-1:0]  w_fin_res;
    logic              w_fin_ill;
    logic              w_fin_dz;

    logic [AccW-1:0]   w_acc_step;
    logic [WIDTH:0]    w_trial;
    logic [WIDTH:0]    w_diff;
    logic              w_ge;
    logic [WIDTH-1:0]  w_rem_step;
    logic [WIDTH-1:0]  w_quo_step;

`ifdef ALU_HILO_EN
    logic [WIDTH-1:0]  r_hi, w_hi_nxt;
`endif

    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Remainder stays below the divisor, so bit WIDTH of the difference is a valid borrow/sign.
    assign w_trial    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_trial - {1'b0, r_dvsr};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_rem_step = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mcand_nxt  = r_mcand;
        w_acc_nxt    = r_acc;
        w_mplier_nxt = r_mplier;
        w_dvsr_nxt   = r_dvsr;
        w_quo_nxt    = r_quo;
        w_rem_nxt    = r_rem;
        w_fin        = 1'b0;
        w_fin_res    = '0;
        w_fin_ill    = 1'b0;
        w_fin_dz     = 1'b0;
`ifdef ALU_HILO_EN
        w_hi_nxt     = r_hi;
`endif
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_fin = 1'b1;
                    case (sel)
                        OpAnd: w_fin_res = a & b;
                        OpOr:  w_fin_res = a | b;
                        OpAdd: w_fin_res = a + b;
                        OpSub: w_fin_res = a - b;
                        OpSlt: w_fin_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                        OpNop: w_fin_res = '0;
                        OpMul: begin
                            w_fin        = 1'b0;
                            w_mcand_nxt  = AccW'(a);
                            w_mplier_nxt = b;
                            w_acc_nxt    = '0;
                            w_cnt_nxt    = '0;
                            w_state_nxt  = StMul;
                        end
                        OpDiv: begin
                            if (b == '0) begin
                                w_fin_res = '1;
                                w_fin_dz  = 1'b1;
`ifdef ALU_HILO_EN
                                w_hi_nxt  = a;
`endif
                            end else begin
                                w_fin       = 1'b0;
                                w_dvsr_nxt  = b;
                                w_quo_nxt   = a;
                                w_rem_nxt   = '0;
                                w_cnt_nxt   = '0;
                                w_state_nxt = StDiv;
                            end
                        end
                        default: w_fin_ill = 1'b1;
                    endcase
                end
            end
            StMul: begin
                w_acc_nxt    = w_acc_step;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + 1'b1;
                if (r_cnt == LastCnt) begin
                    w_fin       = 1'b1;
                    w_fin_res   = w_acc_step[WIDTH-1:0];
                    w_state_nxt = StIdle;
`ifdef ALU_HILO_EN
                    w_hi_nxt    = w_acc_step[AccW-1:WIDTH];
`endif
                end
            end
            StDiv: begin
                w_rem_nxt = w_rem_step;
                w_quo_nxt = w_quo_step;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LastCnt) begin
                    w_fin       = 1'b1;
                    w_fin_res   = w_quo_step;
                    w_state_nxt = StIdle;
`ifdef ALU_HILO_EN
                    w_hi_nxt    = w_rem_step;
`endif
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_mplier   <= '0;
            r_dvsr     <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_illegal  <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mcand  <= w_mcand_nxt;
            r_acc    <= w_acc_nxt;
            r_mplier <= w_mplier_nxt;
            r_dvsr   <= w_dvsr_nxt;
            r_quo    <= w_quo_nxt;
            r_rem    <= w_rem_nxt;
            r_done   <= w_fin;
            if (w_fin) begin
                r_result   <= w_fin_res;
                r_zero     <= (w_fin_res == '0);
                r_illegal  <= w_fin_ill;
                r_div_zero <= w_fin_dz;
            end
        end
    end

`ifdef ALU_HILO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
        end else begin
            r_hi <= w_hi_nxt;
        end
    end

    assign hi = r_hi;
`else
    assign hi = '0;
`endif

    assign busy     = (r_state != StIdle);
    assign done     = r_done;
    assign result   = r_result;
    assign zero     = r_zero;
    assign illegal  = r_illegal;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: single-cycle ops, iterative MUL/DIV, div-by-zero, illegal op, reset abort.
module tb_alu_exec_unit;

    localparam int unsigned W = 32;
`ifdef ALU_HILO_EN
    localparam bit HiloEn = 1'b1;
`else
    localparam bit HiloEn = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   sel   = 4'b0000;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic         div_zero;
    logic [W-1:0] hi;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sel      (sel),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .illegal  (illegal),
        .div_zero (div_zero),
        .hi       (hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start pulse across one rising edge; returns at the falling edge after it.
    task automatic issue(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        sel   = s;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walks the 31 cycles between the start edge and the completion edge.
    task automatic wait_iter(input string tag, input bit repulse);
        int bad_busy;
        int bad_done;
        bad_busy = 0;
        bad_done = 0;
        for (int j = 1; j <= 31; j++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad_busy++;
            if (done !== 1'b0) bad_done++;
            if (repulse && j == 5) begin
                start = 1'b1;
                sel   = 4'b0010;
                a     = 32'd1;
                b     = 32'd1;
            end
            if (repulse && j == 6) start = 1'b0;
        end
        check({tag, " busy held"}, W'(bad_busy), 0);
        check({tag, " no early done"}, W'(bad_done), 0);
        @(negedge clk);
    endtask

    initial begin
        int n_done;

        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst zero", zero, 0);
        check("rst illegal", illegal, 0);
        check("rst div_zero", div_zero, 0);
        check("rst hi", hi, 0);
        rst = 1'b0;

        issue(4'b0010, 32'd5, 32'd7);
        check("add done", done, 1);
        check("add result", result, 32'd12);
        check("add zero", zero, 0);
        check("add busy", busy, 0);
        @(negedge clk);
        check("add done strobe", done, 0);
        check("add result held", result, 32'd12);

        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        check("slt neg<pos", result, 32'd1);
        issue(4'b0111, 32'd1, 32'hFFFF_FFFF);
        check("slt pos<neg", result, 32'd0);
        check("slt zero", zero, 1);

        issue(4'b0110, 32'd3, 32'd3);
        check("sub result", result, 32'd0);
        check("sub zero", zero, 1);

        issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
        check("and result", result, 32'h0000_F000);
        issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
        check("or result", result, 32'h0000_FFF0);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd2);
        check("add wrap", result, 32'd1);

        issue(4'b0011, 32'd7, 32'd6);
        check("mul busy", busy, 1);
        check("mul no done", done, 0);
        wait_iter("mul7x6", 1'b0);
        check("mul done", done, 1);
        check("mul busy clr", busy, 0);
        check("mul result", result, 32'd42);
        check("mul hi", hi, 32'd0);
        @(negedge clk);
        check("mul done strobe", done, 0);

        issue(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_iter("mulmax", 1'b0);
        check("mulmax done", done, 1);
        check("mulmax result", result, 32'd1);
        check("mulmax hi", hi, HiloEn ? 32'hFFFF_FFFE : 32'd0);

        issue(4'b0100, 32'd100, 32'd7);
        wait_iter("div", 1'b1);
        check("div done", done, 1);
        check("div result", result, 32'd14);
        check("div hi", hi, HiloEn ? 32'd2 : 32'd0);
        check("div div_zero", div_zero, 0);
        @(negedge clk);
        check("div repulse ignored", done, 0);
        check("div result held", result, 32'd14);

        issue(4'b0100, 32'd9, 32'd0);
        check("div0 done", done, 1);
        check("div0 busy", busy, 0);
        check("div0 result", result, 32'hFFFF_FFFF);
        check("div0 flag", div_zero, 1);
        check("div0 hi", hi, HiloEn ? 32'd9 : 32'd0);

        issue(4'b1111, 32'd4, 32'd5);
        check("ill done", done, 1);
        check("ill result", result, 32'd0);
        check("ill flag", illegal, 1);
        check("ill div_zero clr", div_zero, 0);
        check("ill hi kept", hi, HiloEn ? 32'd9 : 32'd0);

        issue(4'b1000, 32'd5, 32'd5);
        check("nop result", result, 32'd0);
        check("nop illegal clr", illegal, 0);

        @(negedge clk);
        start = 1'b1;
        sel   = 4'b0010;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clk);
        check("b2b first done", done, 1);
        check("b2b first result", result, 32'd2);
        a = 32'd2;
        b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check("b2b second done", done, 1);
        check("b2b second result", result, 32'd4);
        @(negedge clk);
        check("b2b done drop", done, 0);

        issue(4'b0011, 32'd7, 32'd6);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort no done", W'(n_done), 0);
        check("abort idle", busy, 0);

        issue(4'b0010, 32'd2, 32'd3);
        check("post-abort done", done, 1);
        check("post-abort result", result, 32'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
